tdm_demux: RTL and testbench

Time-division demultiplexer, the receive-side counterpart of the team's 4:1 and 2:1 select muxes. A mux stage serialises NCH lanes onto one bus, one sample per slot, and marks slot 0 with a start-of-frame flag. This block recovers frame alignment, steers each slot back to its lane, and presents complete frames in parallel with a one-cycle valid strobe. It sits at the far end of the serial link, in front of the per-lane consumers.

---
 rtl/tdm_demux_pkg.sv | 15 +
 rtl/tdm_slot_ctr.sv | 37 +++
 rtl/tdm_demux.sv | 139 +++++++++++++
 tb/tb_tdm_demux.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM mux/demux pair: framing FSM encoding and
// the lane slice helper used to place lane k inside a packed frame.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // LSB of lane `lane` inside a packed NCH*width frame.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demux: clear, load-to-1, increment with wrap at
// NCH-1, and a terminal-count flag while sitting on the last slot.
module tdm_slot_ctr #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_load1,
  input  logic            i_inc,
  output logic [SELW-1:0] o_slot,
  output logic            o_tc
);

  localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

  logic [SELW-1:0] r_slot;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (i_clr) begin
      r_slot <= '0;
    end else if (i_load1) begin
      r_slot <= SELW'(1);
    end else if (i_inc) begin
      r_slot <= o_tc ? '0 : r_slot + SELW'(1);
    end
  end

  assign o_slot = r_slot;
  assign o_tc   = (r_slot == LAST);

endmodule

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: locks onto start-of-frame, steers each slot
// to its lane and publishes complete frames with a one-cycle valid strobe.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [WIDTH-1:0]     in_data,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 frame_valid,
  output logic [NCH-1:0]       ch_strobe,
  output logic [SELW-1:0]      slot,
  output logic                 locked,
  output logic                 sync_err
);

  state_t r_state;
  state_t w_next;

  logic            w_wr;
  logic [SELW-1:0] w_wr_idx;
  logic            w_clr;
  logic            w_load1;
  logic            w_inc;
  logic            w_frame;
  logic            w_err;
  logic [SELW-1:0] w_slot;
  logic            w_tc;

  logic [WIDTH-1:0]     r_stage [NCH];
  logic [NCH*WIDTH-1:0] r_out_data;
  logic [NCH-1:0]       r_ch_strobe;
  logic                 r_frame_valid;
  logic                 r_sync_err;

  tdm_slot_ctr #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_load1 (w_load1),
    .i_inc   (w_inc),
    .o_slot  (w_slot),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    if (in_valid) begin
      case (r_state)
        HUNT: if (in_sof) w_next = RUN;
        RUN:  if (!in_sof && w_slot == '0) w_next = HUNT;
      endcase
    end
  end

  // An SOF always restarts at slot 0; only a missing SOF at slot 0 loses lock.
  always_comb begin
    w_wr     = 1'b0;
    w_wr_idx = '0;
    w_clr    = 1'b0;
    w_load1  = 1'b0;
    w_inc    = 1'b0;
    w_frame  = 1'b0;
    w_err    = 1'b0;
    if (in_valid) begin
      case (r_state)
        HUNT: begin
          if (in_sof) begin
            w_wr    = 1'b1;
            w_load1 = 1'b1;
          end
        end
        RUN: begin
          if (in_sof) begin
            w_wr    = 1'b1;
            w_load1 = 1'b1;
            w_err   = (w_slot != '0);
          end else if (w_slot == '0) begin
            w_err = 1'b1;
            w_clr = 1'b1;
          end else begin
            w_wr     = 1'b1;
            w_wr_idx = w_slot;
            w_inc    = 1'b1;
            w_frame  = w_tc;
          end
        end
      endcase
    end
  end

  // NOTE: the staging array is reset explicitly so a reset mid-frame leaves
  // no stale lane data behind; it is small enough to live in flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) r_stage[k] <= '0;
      r_out_data    <= '0;
      r_ch_strobe   <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_ch_strobe   <= w_wr ? (NCH'(1) << w_wr_idx) : '0;
      r_frame_valid <= w_frame;
      r_sync_err    <= w_err;
      if (w_wr) r_stage[w_wr_idx] <= in_data;
      // The last lane comes straight from the bus: it lands in staging on
      // the same edge the frame is published.
      if (w_frame) begin
        for (int k = 0; k < NCH; k++) begin
          r_out_data[lane_lsb(k, WIDTH) +: WIDTH] <= (k == NCH - 1) ? in_data : r_stage[k];
        end
      end
    end
  end

  assign out_data    = r_out_data;
  assign frame_valid = r_frame_valid;
  assign ch_strobe   = r_ch_strobe;
  assign sync_err    = r_sync_err;
  assign slot        = w_slot;
  assign locked      = (r_state == RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (WIDTH=8, NCH=4): framing,
// gaps, hunting, early/missing SOF and asynchronous reset mid-frame.
module tb_tdm_demux;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_sof = 1'b0;
  logic [WIDTH-1:0]     in_data = '0;
  logic [NCH*WIDTH-1:0] out_data;
  logic                 frame_valid;
  logic [NCH-1:0]       ch_strobe;
  logic [SELW-1:0]      slot;
  logic                 locked;
  logic                 sync_err;

  int checks = 0;
  int errors = 0;

  tdm_demux #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SELW  (SELW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_data     (in_data),
    .out_data    (out_data),
    .frame_valid (frame_valid),
    .ch_strobe   (ch_strobe),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: present a sample, let the edge take it, sample outputs 1ns later.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("fv_err_exclusive", 64'(frame_valid & sync_err), 64'd0);
  endtask

  task automatic frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] d3, input int gap, input logic [31:0] exp_out);
    logic [7:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < NCH; k++) begin
      repeat (gap) begin
        step(1'b0, 1'b0, 8'hEE);
        check("gap_strobe", 64'(ch_strobe), 64'd0);
        check("gap_fv", 64'(frame_valid), 64'd0);
        check("gap_slot", 64'(slot), 64'(k));
      end
      step(1'b1, k == 0, d[k]);
      check("strobe", 64'(ch_strobe), 64'(4'b0001 << k));
      check("no_err", 64'(sync_err), 64'd0);
      check("fv", 64'(frame_valid), 64'(k == NCH - 1));
      check("slot_next", 64'(slot), 64'((k + 1) % NCH));
    end
    check("out_data", 64'(out_data), 64'(exp_out));
    check("locked", 64'(locked), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 64'(out_data), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_slot", 64'(slot), 64'd0);
    check("rst_pulses", 64'({frame_valid, sync_err, ch_strobe}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: basic frame, then a back-to-back frame (frame_valid every NCH cycles)
    do_reset();
    frame(8'h11, 8'h22, 8'h33, 8'h44, 0, 32'h44332211);
    frame(8'h55, 8'h66, 8'h77, 8'h88, 0, 32'h88776655);
    step(1'b0, 1'b0, 8'h00);
    check("fv_drop", 64'(frame_valid), 64'd0);
    check("out_hold", 64'(out_data), 64'h88776655);

    // 2: 3-cycle gaps between slots
    frame(8'h11, 8'h22, 8'h33, 8'h44, 3, 32'h44332211);

    // 3: samples without SOF while hunting are dropped
    do_reset();
    step(1'b1, 1'b0, 8'h99);
    check("hunt_strobe0", 64'(ch_strobe), 64'd0);
    check("hunt_locked0", 64'(locked), 64'd0);
    step(1'b1, 1'b0, 8'h98);
    check("hunt_strobe1", 64'(ch_strobe), 64'd0);
    check("hunt_err", 64'(sync_err), 64'd0);
    check("hunt_locked1", 64'(locked), 64'd0);
    check("hunt_slot", 64'(slot), 64'd0);
    frame(8'hA0, 8'hA1, 8'hA2, 8'hA3, 0, 32'hA3A2A1A0);

    // 4: early SOF discards the partial frame
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    check("early_pre_err", 64'(sync_err), 64'd0);
    step(1'b1, 1'b1, 8'h10);
    check("early_err", 64'(sync_err), 64'd1);
    check("early_strobe", 64'(ch_strobe), 64'b0001);
    check("early_slot", 64'(slot), 64'd1);
    check("early_locked", 64'(locked), 64'd1);
    check("early_out", 64'(out_data), 64'hA3A2A1A0);
    step(1'b1, 1'b0, 8'h20);
    check("early_err_once", 64'(sync_err), 64'd0);
    step(1'b1, 1'b0, 8'h30);
    check("early_out_hold", 64'(out_data), 64'hA3A2A1A0);
    step(1'b1, 1'b0, 8'h40);
    check("early_fv", 64'(frame_valid), 64'd1);
    check("early_frame", 64'(out_data), 64'h40302010);

    // 5: missing SOF at slot 0 drops lock, then relock
    step(1'b1, 1'b0, 8'h55);
    check("miss_err", 64'(sync_err), 64'd1);
    check("miss_locked", 64'(locked), 64'd0);
    check("miss_strobe", 64'(ch_strobe), 64'd0);
    check("miss_slot", 64'(slot), 64'd0);
    check("miss_out", 64'(out_data), 64'h40302010);
    step(1'b0, 1'b0, 8'h00);
    check("miss_err_pulse", 64'(sync_err), 64'd0);
    frame(8'hB0, 8'hB1, 8'hB2, 8'hB3, 0, 32'hB3B2B1B0);

    // 6: asynchronous reset after slot 2 of a frame
    step(1'b1, 1'b1, 8'hC0);
    step(1'b1, 1'b0, 8'hC1);
    step(1'b1, 1'b0, 8'hC2);
    check("pre_rst_slot", 64'(slot), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out", 64'(out_data), 64'd0);
    check("async_locked", 64'(locked), 64'd0);
    check("async_slot", 64'(slot), 64'd0);
    check("async_pulses", 64'({frame_valid, sync_err, ch_strobe}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(8'hD0, 8'hD1, 8'hD2, 8'hD3, 0, 32'hD3D2D1D0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
